fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main control decoder.
- Owns the PC register and drives a request/response handshake to instruction memory.
- Holds the fetched instruction stable until the core consumes it; presents instr[6:0] to the decoder as opcode.
- Applies next-PC redirection for branches and jumps (JAL/JALR) resolved by the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/instruction width; only 32 supported.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request valid.
imem_addr  out  XLEN  fetch address, word aligned.
imem_ready  in  1  memory accepts request this cycle.
imem_valid  in  1  read data valid this cycle.
imem_rdata  in  32  instruction word.
stall  in  1  core not ready to consume the held instruction.
branch_taken  in  1  taken conditional branch for the instruction being consumed.
jump  in  1  JAL/JALR for the instruction being consumed.
target_addr  in  XLEN  redirect target.
instr  out  32  held instruction.
instr_pc  out  XLEN  PC of held instruction.
instr_valid  out  1  instr/instr_pc valid.
opcode  out  7  instr[6:0], combinational, feeds control decoder.
illegal_instr  out  1  registered; instr[1:0] != 2'b11 (compressed/illegal encoding).
misaligned  out  1  one-cycle pulse; redirect target[1:0] != 0.

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC.
  - instr_valid=0, illegal_instr=0, misaligned=0.
- States:
  - IDLE -> REQ unconditionally on the first clock after reset release.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready -> WAIT; else stay in REQ with address held stable.
  - WAIT: imem_req=0. On imem_valid, register instr=imem_rdata, instr_pc=pc, instr_valid=1 -> HOLD. imem_valid may coincide with the WAIT-entry cycle +1 at earliest.
  - HOLD: instr_valid=1, instr and instr_pc frozen.
    - stall=1: stay in HOLD.
    - stall=0 (consume): instr_valid<=0, go to REQ.
    - Next pc = {target_addr[31:2],2'b00} if (branch_taken|jump), else pc+4.
- branch_taken/jump/target_addr are sampled only in a HOLD cycle with stall=0; ignored otherwise.
- misaligned pulses for one cycle on a consume with a redirect where target_addr[1:0]!=0. The low bits are still forced to 0 in the new pc.
- PC arithmetic is modulo 2^32: pc+4 from 32'hFFFF_FFFC wraps to 0.
- Throughput: best case 1 instruction per 3 cycles (REQ, WAIT, HOLD) with zero memory wait states. Latency from request acceptance to instr_valid is 1 cycle plus the memory delay.
- Reset mid-operation (any state, including an outstanding WAIT): return immediately to reset values. A late imem_valid arriving in IDLE or REQ is ignored.
- imem_valid outside WAIT is ignored. imem_ready outside REQ is ignored.
- illegal_instr is updated together with instr and cleared on consume.

Test Plan:
- Reset release, RESET_PC=32'h0000_0100, zero-wait memory returning 32'h0000_0293 -> imem_addr=0x100 in first REQ; instr_valid=1 two cycles later; opcode=7'h13; instr_pc=0x100.
- Three sequential consumes, stall=0 -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid high one cycle in every three.
- Hold stall=1 for 5 cycles in HOLD -> instr, instr_pc and instr_valid unchanged; no imem_req; then stall=0 -> next request at pc+4.
- Consume with jump=1, target_addr=32'h0000_2002 -> next imem_addr=0x2000; misaligned pulses for exactly 1 cycle. Repeat with branch_taken=1, target 0x40 -> imem_addr=0x40, no pulse.
- imem_ready low for 4 cycles, then imem_valid delayed 3 cycles -> imem_addr stable throughout REQ; instr captured only on imem_valid.
- Assert rst_n=0 while in WAIT, release, then inject a stale imem_valid -> outputs at reset values; stale data not captured; fetch restarts at RESET_PC.
- Fetch of 32'h0000_0001 -> illegal_instr=1 while held; clears on consume.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a req/resp handshake to instruction
// memory and holds each fetched word for the decoder until the core consumes it.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_valid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] target_addr_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  output logic [6:0]      opcode_o,
  output logic            illegal_instr_o,
  output logic            misaligned_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            illegal_q, illegal_d;
  logic            misaligned_q, misaligned_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    illegal_d    = illegal_q;
    misaligned_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid_i) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          illegal_d  = (imem_rdata_i[1:0] != 2'b11);
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect inputs only matter on the consuming cycle.
        if (!stall_i) begin
          valid_d   = 1'b0;
          illegal_d = 1'b0;
          state_d   = S_REQ;
          if (branch_taken_i || jump_i) begin
            pc_d         = {target_addr_i[XLEN-1:2], 2'b00};
            misaligned_d = (target_addr_i[1:0] != 2'b00);
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP;
      instr_pc_q   <= RESET_PC;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req_o      = (state_q == S_REQ);
  assign imem_addr_o     = pc_q;
  assign instr_o         = instr_q;
  assign instr_pc_o      = instr_pc_q;
  assign instr_valid_o   = valid_q;
  assign opcode_o        = instr_q[6:0];
  assign illegal_instr_o = illegal_q;
  assign misaligned_o    = misaligned_q;

endmodule
